// File: rtl/shared_bus_ic.sv
// Shared-bus interconnect: round-robin arbitration among NM masters, registered
// address decode to NS slaves, per-transaction timeout and unmapped-address error.
module shared_bus_ic #(
   parameter int              NM       = 2,
   parameter int              NS       = 4,
   parameter int              AW       = 32,
   parameter int              DW       = 32,
   parameter logic [NS*AW-1:0] SLV_BASE = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
   parameter logic [NS*AW-1:0] SLV_MASK = {4{32'hF000_0000}},
   parameter int              TMO      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NM-1:0]    m_bstart,
   input  logic [NM*AW-1:0] m_addr,
   input  logic [NM*DW-1:0] m_wdata,
   input  logic [NM-1:0]    m_ttype,
   input  logic [NM*2-1:0]  m_tsize,
   output logic [NM-1:0]    m_bdone,
   output logic [NM-1:0]    m_berr,
   output logic [DW-1:0]    m_rdata,
   output logic [NS-1:0]    s_ss,
   output logic [AW-1:0]    s_addr,
   output logic [DW-1:0]    s_wdata,
   output logic             s_ttype,
   output logic [1:0]       s_tsize,
   input  logic [NS-1:0]    s_bdone,
   input  logic [NS*DW-1:0] s_rdata
);

   localparam int MW = (NM > 1) ? $clog2(NM) : 1;
   localparam int SW = (NS > 1) ? $clog2(NS) : 1;
   localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_e;

   state_e        state_q, state_d;
   logic [MW-1:0] rr_q, rr_d, g_q, g_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          gnt_found;
   logic [MW-1:0] gnt_idx;
   logic [AW-1:0] cand_addr;
   logic          dec_hit;
   logic [SW-1:0] dec_idx;
   logic [MW-1:0] rr_next;

   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NM; k++) begin
         idx = (int'(rr_q) + k) % NM;
         if (!gnt_found && m_bstart[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = MW'(idx);
         end
      end
   end

   // Scan from the top down so the lowest matching slave index ends up winning.
   assign cand_addr = m_addr[int'(gnt_idx)*AW +: AW];
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int i = NS-1; i >= 0; i--) begin
         if ((cand_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
            dec_hit = 1'b1;
            dec_idx = SW'(i);
         end
      end
   end

   assign rr_next = MW'((int'(g_q) + 1) % NM);

   assign s_addr  = m_addr[int'(g_q)*AW +: AW];
   assign s_wdata = m_wdata[int'(g_q)*DW +: DW];
   assign s_ttype = m_ttype[g_q];
   assign s_tsize = m_tsize[int'(g_q)*2 +: 2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         g_q     <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         g_q     <= g_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      g_d     = g_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      s_ss    = '0;
      m_bdone = '0;
      m_berr  = '0;
      m_rdata = '0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (gnt_found) begin
               g_d     = gnt_idx;
               sel_d   = dec_idx;
               state_d = dec_hit ? ACTIVE : ERR;
            end
         end
         ACTIVE: begin
            s_ss[sel_q] = 1'b1;
            if (s_bdone[sel_q]) begin
               m_bdone[g_q] = 1'b1;
               m_rdata      = s_rdata[int'(sel_q)*DW +: DW];
               rr_d         = rr_next;
               cnt_d        = '0;
               state_d      = IDLE;
            end else if (cnt_q == CW'(TMO-1)) begin
               m_bdone[g_q] = 1'b1;
               m_berr[g_q]  = 1'b1;
               rr_d         = rr_next;
               cnt_d        = '0;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ERR: begin
            m_bdone[g_q] = 1'b1;
            m_berr[g_q]  = 1'b1;
            rr_d         = rr_next;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_shared_bus_ic.sv
// Directed bench for shared_bus_ic: single read, round-robin fairness, unmapped
// address error, slave timeout, and asynchronous reset abort with re-arbitration.
module tb_shared_bus_ic;

   localparam int NM = 2;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NM-1:0]    m_bstart;
   logic [NM*AW-1:0] m_addr;
   logic [NM*DW-1:0] m_wdata;
   logic [NM-1:0]    m_ttype;
   logic [NM*2-1:0]  m_tsize;
   logic [NM-1:0]    m_bdone;
   logic [NM-1:0]    m_berr;
   logic [DW-1:0]    m_rdata;
   logic [NS-1:0]    s_ss;
   logic [AW-1:0]    s_addr;
   logic [DW-1:0]    s_wdata;
   logic             s_ttype;
   logic [1:0]       s_tsize;
   logic [NS-1:0]    s_bdone;
   logic [NS*DW-1:0] s_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   shared_bus_ic #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .TMO(16)) dut (
      .clk(clk), .rst(rst),
      .m_bstart(m_bstart), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ttype(m_ttype), .m_tsize(m_tsize),
      .m_bdone(m_bdone), .m_berr(m_berr), .m_rdata(m_rdata),
      .s_ss(s_ss), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_ttype(s_ttype), .s_tsize(s_tsize),
      .s_bdone(s_bdone), .s_rdata(s_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ss"},    64'(s_ss),    64'h0);
      chk({tag, "_bdone"}, 64'(m_bdone), 64'h0);
      chk({tag, "_berr"},  64'(m_berr),  64'h0);
   endtask

   initial begin
      logic [NM-1:0] exp_bd;
      logic [NS-1:0] exp_ss;
      logic [DW-1:0] exp_rd;

      rst      = 1'b1;
      m_bstart = '0;
      m_addr   = '0;
      m_wdata  = '0;
      m_ttype  = '0;
      m_tsize  = '0;
      s_bdone  = '0;
      s_rdata  = {32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk_idle("rst");
      chk("rst_rdata", 64'(m_rdata), 64'h0);
      rst = 1'b0;

      // Single read of slave 1, zero-wait: one-cycle latency
      @(negedge clk);
      m_bstart = 2'b01;
      m_addr[31:0] = 32'h2000_0010;
      m_wdata[31:0] = 32'h0BAD_F00D;
      m_ttype = 2'b00;
      m_tsize = 4'b0010;
      #1; chk_idle("rd_idle");
      @(negedge clk);
      s_bdone = 4'b0010;
      #1;
      chk("rd_ss",    64'(s_ss),    64'h2);
      chk("rd_addr",  64'(s_addr),  64'h2000_0010);
      chk("rd_wdata", 64'(s_wdata), 64'h0BAD_F00D);
      chk("rd_tsize", 64'(s_tsize), 64'h2);
      chk("rd_ttype", 64'(s_ttype), 64'h0);
      chk("rd_bdone", 64'(m_bdone), 64'h1);
      chk("rd_berr",  64'(m_berr),  64'h0);
      chk("rd_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
      @(negedge clk);
      m_bstart = '0;
      s_bdone  = '0;
      #1; chk_idle("rd_after");

      // Fresh reset so round-robin pointer starts at 0
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Both masters request continuously: grants 0,1,0 with an IDLE gap between
      m_bstart = 2'b11;
      m_addr   = {32'h3000_0004, 32'h1000_0000};
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         s_bdone = 4'b1111;
         #1;
         exp_bd = (t == 1) ? 2'b10 : 2'b01;
         exp_ss = (t == 1) ? 4'b0100 : 4'b0001;
         exp_rd = (t == 1) ? 32'h3333_3333 : 32'h1111_1111;
         chk($sformatf("rr%0d_bdone", t), 64'(m_bdone), 64'(exp_bd));
         chk($sformatf("rr%0d_ss", t),    64'(s_ss),    64'(exp_ss));
         chk($sformatf("rr%0d_rdata", t), 64'(m_rdata), 64'(exp_rd));
         @(negedge clk);
         s_bdone = '0;
         #1; chk_idle($sformatf("rr%0d_gap", t));
      end

      // Master 1 write to unmapped address: one ERR cycle
      m_bstart = 2'b10;
      m_addr[63:32] = 32'h9000_0000;
      m_ttype = 2'b10;
      @(negedge clk); #1;
      chk("err_ss",    64'(s_ss),    64'h0);
      chk("err_bdone", 64'(m_bdone), 64'h2);
      chk("err_berr",  64'(m_berr),  64'h2);
      chk("err_rdata", 64'(m_rdata), 64'h0);
      @(negedge clk);
      m_bstart = '0;
      #1; chk_idle("err_after");

      // Slave 3 never responds; other slaves strobe bdone and must be ignored
      m_bstart = 2'b01;
      m_addr[31:0] = 32'h4000_0000;
      m_ttype = 2'b00;
      s_bdone = 4'b0111;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk); #1;
         chk($sformatf("tmo%0d_ss", c), 64'(s_ss), 64'h8);
         if (c < 15) begin
            chk($sformatf("tmo%0d_bdone", c), 64'(m_bdone), 64'h0);
         end else begin
            chk("tmo_bdone", 64'(m_bdone), 64'h1);
            chk("tmo_berr",  64'(m_berr),  64'h1);
            chk("tmo_rdata", 64'(m_rdata), 64'h0);
         end
      end
      @(negedge clk);
      m_bstart = '0;
      s_bdone  = '0;
      #1; chk_idle("tmo_after");

      // Reset during ACTIVE (pointer is 1 here); master 1 keeps its request
      m_bstart = 2'b10;
      m_addr   = {32'h1000_0000, 32'h2000_0000};
      @(negedge clk); #1;
      chk("ab_ss_pre", 64'(s_ss), 64'h1);
      #2;
      rst = 1'b1;
      #1;
      chk_idle("ab_rst");
      chk("ab_rdata", 64'(m_rdata), 64'h0);
      @(negedge clk); #1;
      chk_idle("ab_hold");
      rst = 1'b0;
      m_bstart = 2'b11;
      @(negedge clk);
      s_bdone = 4'b0011;
      #1;
      chk("ab_g0_bdone", 64'(m_bdone), 64'h1);
      chk("ab_g0_ss",    64'(s_ss),    64'h2);
      chk("ab_g0_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
      @(negedge clk);
      m_bstart = 2'b10;
      s_bdone  = '0;
      #1; chk_idle("ab_gap");
      @(negedge clk);
      s_bdone = 4'b0001;
      #1;
      chk("ab_g1_bdone", 64'(m_bdone), 64'h2);
      chk("ab_g1_ss",    64'(s_ss),    64'h1);
      chk("ab_g1_rdata", 64'(m_rdata), 64'h1111_1111);
      @(negedge clk);
      m_bstart = '0;
      s_bdone  = '0;
      #1; chk_idle("end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shared_bus_ic.md
SHARED_BUS_IC -- requirements
Module: shared_bus_ic

Interface
REQ-001 SHALL have parameter NM, default 2: number of bus masters.
REQ-002 SHALL have parameter NS, default 4: number of slaves.
REQ-003 SHALL have parameter AW, default 32: address width.
REQ-004 SHALL have parameter DW, default 32: data width.
REQ-005 SHALL have parameter SLV_BASE, default {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000}: packed NS x AW base table, slave 0 in LSBs.
REQ-006 SHALL have parameter SLV_MASK, default all 32'hF000_0000: packed NS x AW mask table; slave i matches when (addr & mask_i) == base_i.
REQ-007 SHALL have parameter TMO, default 16: cycles a slave may take before timeout.
REQ-008 clk  input  1  single clock; all state on rising edge.
REQ-009 rst  input  1  reset; asynchronous and active-high.
REQ-010 m_bstart  input  NM  per-master request, held high until its m_bdone.
REQ-011 m_addr, m_wdata  input  NM*AW, NM*DW  per-master address and write data, stable while m_bstart high.
REQ-012 m_ttype, m_tsize  input  NM, NM*2  per-master READ(0)/WRITE(1); BYTE(0)/HALFWORD(1)/WORD(2).
REQ-013 m_bdone, m_berr  output  NM  one-cycle completion and error strobes per master.
REQ-014 m_rdata  output  DW  read data shared by all masters, valid with m_bdone.
REQ-015 s_ss  output  NS  one-hot slave select.
REQ-016 s_addr, s_wdata, s_ttype, s_tsize  output  AW, DW, 1, 2  forwarded fields of the granted master.
REQ-017 s_bdone  input  NS  per-slave completion.
REQ-018 s_rdata  input  NS*DW  per-slave read data.

Function
REQ-019 SHALL implement FSM states IDLE, ACTIVE, ERR.
REQ-020 IDLE: when any m_bstart is high, SHALL register grant g by round-robin starting at pointer rr, then go to ACTIVE (or ERR if g's address matches no slave) next cycle.
REQ-021 Round-robin: search order rr, rr+1, ..., wrapping modulo NM; on each completion rr SHALL become (g+1) mod NM.
REQ-022 Address decode SHALL be registered with the grant; on multiple matches the lowest slave index wins.
REQ-023 ACTIVE: s_ss SHALL be one-hot for the decoded slave; s_* fields SHALL mirror master g combinationally.
REQ-024 ACTIVE: when s_bdone of the selected slave is high, SHALL pulse m_bdone[g] the same cycle with m_rdata = that slave's s_rdata, and return to IDLE next cycle.
REQ-025 s_bdone from non-selected slaves SHALL be ignored.
REQ-026 ACTIVE: a counter SHALL count from 0; when it reaches TMO-1 without s_bdone, SHALL pulse m_bdone[g] and m_berr[g], with m_rdata = 0, and return to IDLE.
REQ-027 ERR: SHALL last exactly one cycle, pulse m_bdone[g] and m_berr[g] with m_rdata = 0, and keep s_ss = 0, then return to IDLE.
REQ-028 s_ss SHALL be 0 in IDLE and ERR.
REQ-029 Minimum latency (m_bstart rise to m_bdone) SHALL be 1 cycle with zero-wait slave.
REQ-030 Back-to-back: one IDLE cycle SHALL separate consecutive transactions.
REQ-031 m_bstart dropping before its completion is illegal; behaviour is undefined.

Reset
REQ-032 While rst is high: state = IDLE, rr = 0, counter = 0, g = 0; s_ss, m_bdone, m_berr = 0; m_rdata = 0.
REQ-033 rst asserted mid-transaction SHALL abort it with no m_bdone; the pending master re-arbitrates after release.

Verification
REQ-034 Single master 0 READ WORD at 0x2000_0010, slave 1 bdone next cycle with rdata 0xDEADBEEF -> s_ss=4'b0010, m_bdone[0] one cycle, m_rdata=0xDEADBEEF.
REQ-035 Masters 0 and 1 request together, three times, rr=0 at start -> grants 0,1,0, with one IDLE gap between each.
REQ-036 Master 1 WRITE at 0x9000_0000 (unmapped) -> ERR, m_bdone[1]=m_berr[1]=1 for one cycle, s_ss stays 0.
REQ-037 Slave 3 never asserts bdone, TMO=16 -> after 16 ACTIVE cycles m_berr=1, s_ss drops, FSM back to IDLE.
REQ-038 rst pulsed during ACTIVE -> all outputs 0 immediately, rr=0, no m_bdone; after release the held request is re-granted.
